// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read memory.
// Port 0 has fixed priority; port 1 is forced through after MAX_WAIT lost arbitrations.
//
// state | meaning
// IDLE  | arbitrate between m0_req_i / m1_req_i, latch winner's command
// ISSUE | command on the memory bus, owner's gnt high
// RESP  | read data on mem_rdata_i, captured into owner's rdata
module mem_port_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_gnt_o,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic          m1_gnt_o,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_we_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          owner_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   state_t        state_q, state_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic          we_q, we_d;
   logic          owner_q, owner_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          mem_we_q, mem_we_d;
   logic          m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
   logic          m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic          pick1;

   assign pick1 = m1_req_i && (!m0_req_i || (wait_cnt_q == MAX_W));

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      we_d        = we_q;
      owner_d     = owner_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      m0_gnt_d    = 1'b0;
      m1_gnt_d    = 1'b0;
      m0_rvalid_d = 1'b0;
      m1_rvalid_d = 1'b0;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
      case (state_q)
         IDLE: begin
            if (pick1) begin
               owner_d     = 1'b1;
               we_d        = m1_we_i;
               mem_addr_d  = m1_addr_i;
               mem_wdata_d = m1_wdata_i;
               mem_we_d    = m1_we_i;
               m1_gnt_d    = 1'b1;
               wait_cnt_d  = 4'd0;
               state_d     = ISSUE;
            end else if (m0_req_i) begin
               owner_d     = 1'b0;
               we_d        = m0_we_i;
               mem_addr_d  = m0_addr_i;
               mem_wdata_d = m0_wdata_i;
               mem_we_d    = m0_we_i;
               m0_gnt_d    = 1'b1;
               state_d     = ISSUE;
               // port 1 lost this round only if it was actually asking
               if (!m1_req_i) begin
                  wait_cnt_d = 4'd0;
               end else if (wait_cnt_q != MAX_W) begin
                  wait_cnt_d = wait_cnt_q + 4'd1;
               end
            end else begin
               wait_cnt_d = 4'd0;
            end
         end
         ISSUE: begin
            state_d = we_q ? IDLE : RESP;
         end
         RESP: begin
            if (owner_q) begin
               m1_rdata_d  = mem_rdata_i;
               m1_rvalid_d = 1'b1;
            end else begin
               m0_rdata_d  = mem_rdata_i;
               m0_rvalid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         wait_cnt_q  <= 4'd0;
         we_q        <= 1'b0;
         owner_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         we_q        <= we_d;
         owner_q     <= owner_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         m0_gnt_q    <= m0_gnt_d;
         m1_gnt_q    <= m1_gnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign m0_gnt_o    = m0_gnt_q;
   assign m1_gnt_o    = m1_gnt_q;
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_we_o    = mem_we_q;
   assign owner_o     = owner_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [15:0] m0_rdata, m1_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, owner, busy;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic        excl_viol = 1'b0;
   logic [15:0] mem_arr [0:255];

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(3)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
      .mem_rdata_i(mem_rdata), .owner_o(owner), .busy_o(busy)
   );

   // memory model: preloaded while rst is high, read data one cycle after address
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 16'(i * 3);
         mem_arr[8'h10] <= 16'hBEEF;
         mem_arr[8'h20] <= 16'hA5A5;
         mem_arr[8'hFF] <= 16'h5A5A;
      end else if (mem_we) begin
         mem_arr[mem_addr[7:0]] <= mem_wdata;
      end
      mem_rdata <= mem_arr[mem_addr[7:0]];
   end

   always @(negedge clk) begin
      if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid)) excl_viol = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [7:0] seq;
   int         ng;
   logic       m1_seen;

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      repeat (3) step();
      chk("reset_ctrl", {busy, owner, mem_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
      chk("reset_data", {mem_addr, mem_wdata}, 0);
      chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
      rst = 1'b0;
      step();

      // single read on port 0
      m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
      step();
      chk("rd_gnt", {m0_gnt, m1_gnt, mem_we, busy, owner}, 5'b10010);
      chk("rd_addr", mem_addr, 16'h0010);
      m0_req = 0;
      step();
      chk("rd_rvalid_early", {m0_rvalid, mem_we, busy}, 3'b001);
      step();
      chk("rd_rvalid", {m0_rvalid, m1_rvalid, busy}, 3'b100);
      chk("rd_rdata", m0_rdata, 16'hBEEF);
      chk("rd_m1_quiet", m1_rdata, 16'h0000);
      step();
      chk("rd_rvalid_pulse", m0_rvalid, 0);

      // single write on port 1
      m1_req = 1; m1_we = 1; m1_addr = 16'h0200; m1_wdata = 16'h1234;
      step();
      chk("wr_gnt", {m1_gnt, m0_gnt, mem_we, owner, busy}, 5'b10111);
      chk("wr_bus", {mem_addr, mem_wdata}, {16'h0200, 16'h1234});
      m1_req = 0;
      step();
      chk("wr_done", {mem_we, m1_gnt, busy}, 3'b000);
      chk("wr_addr_hold", mem_addr, 16'h0200);
      step();
      chk("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);

      // contention: continuous writes from both ports
      m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 16'h1111;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0180; m1_wdata = 16'h2222;
      seq = 0; ng = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (m0_gnt || m1_gnt) begin
            seq = {seq[6:0], m1_gnt};
            ng++;
         end
      end
      m0_req = 0; m1_req = 0;
      chk("cont_order", seq, 8'h11);
      chk("cont_count", ng, 8);
      step(); step();

      // simultaneous single reads: port 0 first, port 1 at next idle
      m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
      m1_req = 1; m1_we = 0; m1_addr = 16'hFFFF;
      step();
      chk("pri_gnt0", {m0_gnt, m1_gnt}, 2'b10);
      chk("pri_addr0", mem_addr, 16'h0020);
      m0_req = 0;
      step();
      chk("pri_wait1", m1_gnt, 0);
      step();
      chk("pri_rvalid0", {m0_rvalid, m1_rvalid}, 2'b10);
      chk("pri_rdata0", m0_rdata, 16'hA5A5);
      step();
      chk("pri_gnt1", {m0_gnt, m1_gnt, owner}, 3'b011);
      chk("pri_addr1", mem_addr, 16'hFFFF);
      m1_req = 0;
      step();
      chk("pri_gap", {m0_rvalid, m1_rvalid}, 2'b00);
      step();
      chk("pri_rvalid1", {m0_rvalid, m1_rvalid}, 2'b01);
      chk("pri_rdata", {m1_rdata, m0_rdata}, {16'h5A5A, 16'hA5A5});
      step();

      // reset during RESP of a read
      m0_req = 1; m0_we = 0; m0_addr = 16'h0030;
      step();
      m0_req = 0;
      step();
      rst = 1'b1;
      step();
      chk("rst_ctrl", {busy, owner, mem_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
      chk("rst_data", {mem_addr, m0_rdata}, 0);
      rst = 1'b0;
      step();
      chk("rst_no_rvalid", m0_rvalid, 0);
      m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
      step();
      chk("rst_rd_gnt", {m0_gnt, mem_addr}, {1'b1, 16'h0010});
      m0_req = 0;
      step(); step();
      chk("rst_rd_done", {m0_rvalid, m0_rdata}, {1'b1, 16'hBEEF});
      step();

      // reset during ISSUE of a write
      m1_req = 1; m1_we = 1; m1_addr = 16'h0040; m1_wdata = 16'h7777;
      step();
      chk("rstw_issue", mem_we, 1);
      m1_req = 0;
      rst = 1'b1;
      step();
      chk("rstw_drop", {mem_we, m1_gnt, busy}, 3'b000);
      rst = 1'b0;
      step();

      // dropped port-1 request while port 0 wins; counter must clear afterwards
      m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0050; m1_wdata = 16'h5555;
      step();
      chk("drop_gnt0", {m0_gnt, m1_gnt}, 2'b10);
      m0_req = 0; m1_req = 0;
      m1_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (m1_gnt) m1_seen = 1'b1;
      end
      chk("drop_no_gnt1", m1_seen, 0);
      m0_req = 1; m0_we = 1; m0_addr = 16'h0100;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0180;
      seq = 0; ng = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (m0_gnt || m1_gnt) begin
            seq = {seq[6:0], m1_gnt};
            ng++;
         end
      end
      m0_req = 0; m1_req = 0;
      chk("drop_cnt_cleared", {seq, 8'(ng)}, {8'h01, 8'd4});
      step(); step();

      chk("exclusive", excl_viol, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port 16-bit memory between two requesters: port 0 (CPU core) and port 1 (DMA / debug loader).
- Port 0 has fixed priority, with a starvation guard for port 1.
- Sits between the requesters and the memory model. It drives mem_addr / mem_wdata / mem_we and routes mem_rdata back to the owner.
- Memory has synchronous read: data appears one cycle after the address is presented.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 3, number of consecutive lost arbitrations port 1 tolerates before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request; hold stable with m0_we / m0_addr / m0_wdata until m0_gnt.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  AW  port 0 address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  one-cycle pulse: port 0 request issued to memory.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid (reads only).
- m0_rdata  out  DW  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for port 1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DW  memory read data, valid one cycle after the address.
- owner  out  1  port owning the current transaction; meaningful only when busy=1.
- busy  out  1  high in ISSUE and RESP.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, starvation counter wait_cnt = 0.

State machine:
- IDLE:
  - Sample m0_req / m1_req.
  - Winner rule: port 1 if (m1_req && (!m0_req || wait_cnt == MAX_WAIT)); else port 0 if m0_req.
  - On a winner: latch owner, we, addr, wdata; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_addr / mem_wdata / mem_we are driven from the latched values; mem_we=1 only for writes.
  - The owner's gnt is 1; the other gnt is 0.
  - Write: go to IDLE. Read: go to RESP.
- RESP (exactly one cycle):
  - mem_we=0.
  - Owner's rdata <= mem_rdata; its rvalid pulses in the cycle after RESP, i.e. registered.
  - Go to IDLE.
- Timing for a request sampled in IDLE at cycle N:
  - gnt and memory command at N+1.
  - Read data sampled in RESP at N+2.
  - rvalid / rdata at N+3.
  - The next arbitration can happen in IDLE at N+3 (read) or N+2 (write).
- Pipelining: an rvalid pulse may coincide with the following IDLE cycle. IDLE does not wait for rvalid.

Output hold rules:
- mem_addr / mem_wdata hold their last value outside ISSUE/RESP.
- mem_we is 0 outside ISSUE.
- m*_rdata holds its last value until the next read for that port.

Starvation counter (wait_cnt):
- In IDLE with m1_req=1 and port 0 winning: wait_cnt += 1, saturating at MAX_WAIT.
- When port 1 wins, or in IDLE with m1_req=0: wait_cnt = 0.
- Otherwise it holds.

Boundary conditions:
- Simultaneous requests with wait_cnt < MAX_WAIT: port 0 wins.
- A requester that drops req before its gnt is simply not served. There is no error.
- req still high in the cycle after gnt is a new request, evaluated at the next IDLE.
- The address is passed through unchanged; there is no wrap logic. Address 16'hFFFF is legal.
- rst asserted in any state: next cycle is IDLE with all outputs 0. In-flight reads produce no rvalid; an in-flight write's mem_we drops in that cycle.
- Exactly one gnt pulse per transaction. m0_gnt and m1_gnt are never high together, and neither are m0_rvalid and m1_rvalid.

Test Plan:
- Single read: m0 read addr 0x0010, memory returns 0xBEEF -> m0_gnt at N+1 with mem_addr=0x0010, mem_we=0; m0_rvalid and m0_rdata=0xBEEF at N+3; m1 outputs stay 0.
- Single write: m1 write addr 0x0200, data 0x1234 -> at N+1 m1_gnt=1, mem_we=1, mem_addr=0x0200, mem_wdata=0x1234; mem_we=0 at N+2; no rvalid.
- Contention with MAX_WAIT=3: m0 and m1 both request continuous writes -> grant order m0, m0, m0, m1, m0, m0, m0, m1; wait_cnt never exceeds 3.
- Priority without starvation: simultaneous single requests from idle -> m0 granted first, m1 granted at the next IDLE; back-to-back reads give rvalid spacing of 3 cycles.
- Reset mid-read: assert rst during RESP -> next cycle busy=0, no m*_rvalid, all outputs 0; a new m0 read then completes normally.
- Dropped request: m1_req pulses for 1 cycle while m0 owns memory -> m1_gnt never asserts; wait_cnt returns to 0 when m1_req is low in IDLE.
